// File: rtl/hvac_seq_pkg.sv
// rtl/hvac_seq_pkg.sv - state/mode encodings and default timing for the HVAC sequencer
package hvac_seq_pkg;

  localparam int CNT_W_DEF     = 8;
  localparam int T_PRE_DEF     = 4;
  localparam int T_MIN_ON_DEF  = 16;
  localparam int T_POST_DEF    = 8;
  localparam int T_MIN_OFF_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFAN   = 3'd1,
    ST_RUN_HEAT = 3'd2,
    ST_RUN_COOL = 3'd3,
    ST_POSTFAN  = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_COOL = 2'd2
  } mode_e;

endpackage

// File: rtl/hvac_seq_ctrl_timer.sv
// rtl/hvac_seq_ctrl_timer.sv - hvac_seq_timer: loadable saturating down-counter with registered nonzero flag
module hvac_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             nonzero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nonzero_q, nonzero_d;

  // Load wins over counting; counting stops at zero so the flag stays low once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    nonzero_d = (cnt_d != '0);
  end

  // Counter and flag registers; the flag tracks the registered count exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      nonzero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      nonzero_q <= nonzero_d;
    end
  end

  assign nonzero = nonzero_q;

endmodule

// File: rtl/hvac_seq_ctrl.sv
// rtl/hvac_seq_ctrl.sv - heat/cool/fan sequencer with anti-short-cycle lockout; HVAC_SEQ_POSTFAN_EN adds fan post-run
module hvac_seq_ctrl
  import hvac_seq_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int T_PRE     = T_PRE_DEF,
  parameter int T_MIN_ON  = T_MIN_ON_DEF,
  parameter int T_POST    = T_POST_DEF,
  parameter int T_MIN_OFF = T_MIN_OFF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic heat_req,
  input  logic cool_req,
  input  logic fan_req,
  input  logic fault,
  output logic den,
  output logic bom,
  output logic quat,
  output logic busy,
  output logic lockout,
  output logic conflict
);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic   den_q, den_d, bom_q, bom_d, quat_q, quat_d;
  logic   busy_q, busy_d, conflict_q, conflict_d;

  logic             ph_load, ph_nz, lk_load, lk_nz;
  logic [CNT_W-1:0] ph_val;
  logic             heat_only, cool_only, lat_req, opp_req;

  hvac_seq_timer #(.CNT_W(CNT_W)) u_phase_tmr (
    .clk(clk), .rst(rst), .load(ph_load), .load_val(ph_val), .nonzero(ph_nz)
  );

  hvac_seq_timer #(.CNT_W(CNT_W)) u_lock_tmr (
    .clk(clk), .rst(rst), .load(lk_load), .load_val(CNT_W'(T_MIN_OFF)), .nonzero(lk_nz)
  );

  // Next state, mode latch and timer loads; phase loads are length-1 so a phase lasts exactly its length.
  always_comb begin
    heat_only = heat_req & ~cool_req;
    cool_only = cool_req & ~heat_req;
    lat_req   = (mode_q == MODE_HEAT) ? heat_req : cool_req;
    opp_req   = (mode_q == MODE_HEAT) ? cool_req : heat_req;
    state_d   = state_q;
    mode_d    = mode_q;
    ph_load   = 1'b0;
    ph_val    = '0;
    lk_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!lk_nz && (heat_only || cool_only)) begin
          state_d = ST_PREFAN;
          mode_d  = heat_only ? MODE_HEAT : MODE_COOL;
          ph_load = 1'b1;
          ph_val  = CNT_W'(T_PRE - 1);
        end
      end
      ST_PREFAN: begin
        if (!lat_req) begin
          state_d = ST_IDLE;
        end else if (!ph_nz) begin
          state_d = (mode_q == MODE_HEAT) ? ST_RUN_HEAT : ST_RUN_COOL;
          ph_load = 1'b1;
          ph_val  = CNT_W'(T_MIN_ON - 1);
        end
      end
      ST_RUN_HEAT, ST_RUN_COOL: begin
        // The phase timer is reloaded with the post-run length in both builds; IDLE ignores it.
        if (!ph_nz && (!lat_req || opp_req)) begin
          lk_load = 1'b1;
          ph_load = 1'b1;
          ph_val  = CNT_W'(T_POST - 1);
`ifdef HVAC_SEQ_POSTFAN_EN
          state_d = ST_POSTFAN;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_POSTFAN: begin
        if (!ph_nz) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!fault) begin
          state_d = ST_IDLE;
          lk_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Fault overrides every transition; the lockout is loaded when FAULT is left instead.
    if (fault) begin
      state_d = ST_FAULT;
      ph_load = 1'b0;
      lk_load = 1'b0;
    end
  end

  // Moore output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    den_d      = (state_d == ST_RUN_HEAT);
    bom_d      = (state_d == ST_RUN_COOL);
    busy_d     = (state_d != ST_IDLE);
    conflict_d = (state_d == ST_IDLE) && heat_req && cool_req;
    case (state_d)
      ST_IDLE:  quat_d = fan_req;
      ST_FAULT: quat_d = 1'b0;
      default:  quat_d = 1'b1;
    endcase
  end

  // State, mode and output registers; reset drops every drive immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_NONE;
      den_q      <= 1'b0;
      bom_q      <= 1'b0;
      quat_q     <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      den_q      <= den_d;
      bom_q      <= bom_d;
      quat_q     <= quat_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign den      = den_q;
  assign bom      = bom_q;
  assign quat     = quat_q;
  assign busy     = busy_q;
  assign lockout  = lk_nz;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_hvac_seq_ctrl.sv
// tb/tb_hvac_seq_ctrl.sv - randomized and scenario bench for hvac_seq_ctrl against a cycle-age reference model
module tb_hvac_seq_ctrl;

  localparam int CNT_W     = 8;
  localparam int T_PRE     = 4;
  localparam int T_MIN_ON  = 16;
  localparam int T_POST    = 8;
  localparam int T_MIN_OFF = 20;

  localparam int M_IDLE = 0, M_PRE = 1, M_HEAT = 2, M_COOL = 3, M_POST = 4, M_FAULT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic heat_req = 1'b0, cool_req = 1'b0, fan_req = 1'b0, fault = 1'b0;
  logic den, bom, quat, busy, lockout, conflict;
  wire  [5:0] outs = {den, bom, quat, busy, lockout, conflict};

  int checks = 0;
  int failures = 0;

  // reference model: phase = state name + cycles spent in it; lockout = absolute cycle it ends
  int   ms, age, cyc, lock_until;
  logic mheat;
  logic [5:0] exp_out;

  always #5 clk = ~clk;

  hvac_seq_ctrl #(
    .CNT_W(CNT_W), .T_PRE(T_PRE), .T_MIN_ON(T_MIN_ON), .T_POST(T_POST), .T_MIN_OFF(T_MIN_OFF)
  ) dut (
    .clk(clk), .rst(rst), .heat_req(heat_req), .cool_req(cool_req), .fan_req(fan_req),
    .fault(fault), .den(den), .bom(bom), .quat(quat), .busy(busy), .lockout(lockout),
    .conflict(conflict)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = M_IDLE; age = 1; mheat = 1'b0; lock_until = 0; exp_out = '0;
  endtask

  task automatic model_step(input logic h, input logic c, input logic f, input logic fr);
    int   nxt;
    logic lk_now, want, other, q;
    lk_now = (cyc < lock_until);
    want   = mheat ? h : c;
    other  = mheat ? c : h;
    nxt    = ms;
    if (f) nxt = M_FAULT;
    else begin
      case (ms)
        M_IDLE: if (!lk_now && (h ^ c)) begin nxt = M_PRE; mheat = h; end
        M_PRE: begin
          if (!want) nxt = M_IDLE;
          else if (age == T_PRE) nxt = mheat ? M_HEAT : M_COOL;
        end
        M_HEAT, M_COOL: begin
          if (age >= T_MIN_ON && (!want || other)) begin
            lock_until = cyc + 1 + T_MIN_OFF;
`ifdef HVAC_SEQ_POSTFAN_EN
            nxt = M_POST;
`else
            nxt = M_IDLE;
`endif
          end
        end
        M_POST: if (age == T_POST) nxt = M_IDLE;
        default: begin nxt = M_IDLE; lock_until = cyc + 1 + T_MIN_OFF; end
      endcase
    end
    age = (nxt == ms) ? age + 1 : 1;
    ms  = nxt;
    cyc++;
    q = (ms == M_IDLE) ? fr : (ms != M_FAULT);
    exp_out = {ms == M_HEAT, ms == M_COOL, q, ms != M_IDLE, cyc < lock_until,
               (ms == M_IDLE) && h && c};
  endtask

  // called at a negedge; returns at the next negedge
  task automatic cycle(input logic h, input logic c, input logic f, input logic fr);
    heat_req = h; cool_req = c; fault = f; fan_req = fr;
    @(posedge clk);
    model_step(h, c, f, fr);
    #1;
    check_eq("outs{den,bom,quat,busy,lockout,conflict}", outs, exp_out);
    check_eq("den_bom_exclusive", den & bom, 0);
    @(negedge clk);
  endtask

  initial begin
    int n_bom, n_pre, n_lock, n_den;
    logic seen_bom;
    logic h, c, f, fr;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_outs", outs, 0);
    rst = 1'b1;

    // cooling request: pre-run, minimum run despite early drop, post-run (build dependent)
    n_bom = 0; n_pre = 0; seen_bom = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, i < 5, 1'b0, 1'b0);
      if (bom) begin n_bom++; seen_bom = 1'b1; end
      if (quat && !seen_bom) n_pre++;
    end
    check_eq("prefan_len", n_pre, T_PRE);
    check_eq("min_on_len", n_bom, T_MIN_ON);

    // heat request during lockout waits; then run and fault mid RUN_HEAT
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("heat_running", den, 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("fault_drops_den_quat", {den, quat}, 0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_lock = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (lockout) n_lock++;
    end
    check_eq("fault_lockout_len", n_lock, T_MIN_OFF);

    // heat drop inside pre-run: abort, no heater, no lockout
    n_den = 0; n_lock = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(i < 2, 1'b0, 1'b0, 1'b0);
      if (den) n_den++;
      if (lockout) n_lock++;
    end
    check_eq("prefan_abort_den", n_den, 0);
    check_eq("prefan_abort_lockout", n_lock, 0);

    // simultaneous requests in IDLE
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("conflict_state", {conflict, busy, den, bom}, 4'b1000);

    // asynchronous reset in the middle of RUN_COOL
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pre_reset_bom", bom, 1);
    #2 rst = 1'b0;
    #1 check_eq("async_reset_outs", outs, 0);
    model_reset();
    @(negedge clk);
    check_eq("held_reset_outs", outs, 0);
    rst = 1'b1; heat_req = 0; cool_req = 0; fan_req = 0; fault = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("restart_no_lockout", {busy, lockout}, 2'b10);

    // randomized long-hold stimulus
    h = 0; c = 0; f = 0; fr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) h = ~h;
      if ($urandom_range(0, 24) == 0) c = ~c;
      if ($urandom_range(0, 14) == 0) fr = ~fr;
      if (f) begin
        if ($urandom_range(0, 3) == 0) f = 1'b0;
      end else if ($urandom_range(0, 299) == 0) f = 1'b1;
      cycle(h, c, f, fr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
